// File: rtl/stage_mem_wb_pkg.sv
// Shared widths, load/store funct3 encodings and the memory FSM state type.
// No logic; imported by the M/W stage and its lane-alignment helper.
// Pure definitions, so it has no latency and no flow control.
package stage_mem_wb_pkg;

  localparam int XLEN    = 32;
  localparam int NREG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/stage_mem_wb_load_store_align.sv
// Store lane shift/strobes, load byte/half extract with extension, alignment check.
// Purely combinational, zero cycles.
// No flow control; the caller qualifies every output with its own op valids.
module stage_mem_wb_load_store_align
  import stage_mem_wb_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wstrb = 4'b1111;
    wdata = store_data;
    case (funct3)
      F3_SB: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_SH: begin
        wstrb = 4'b0011 << addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: ;
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data = {24'd0, byte_sel};
      F3_LHU:  load_data = {16'd0, half_sel};
      default: ;
    endcase
  end

  // Stores share the size encodings of LH/LW, so one check covers both.
  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: misaligned = addr_lo[0];
      F3_LW:         misaligned = (addr_lo != 2'd0);
      default:       ;
    endcase
  end

endmodule

// File: rtl/stage_mem_wb.sv
// M/W stage: variable-latency data memory access, divider merge into the single write port.
// One cycle M -> W for completed ops; memory ops add the memory's wait cycles.
// mem_stall holds M and upstream while an access waits for ack or a retiring divide takes W.
module stage_mem_wb
  import stage_mem_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    m_pc,
  input  logic [XLEN-1:0]    m_inst,
  input  logic [XLEN-1:0]    m_alu_result,
  input  logic [XLEN-1:0]    m_store_data,
  input  logic [NREG_AW-1:0] m_rd_addr,
  input  logic [NREG_AW-1:0] m_rs2_addr,
  input  logic               m_reg_we,
  input  logic               m_mem_we,
  input  logic               m_load,
  input  logic [2:0]         m_funct3,
  input  logic [6:0]         div_busy_7,
  input  logic [XLEN-1:0]    div_quotient,
  input  logic [XLEN-1:0]    div_remainder,
  input  logic [XLEN-1:0]    div_pc_done,
  input  logic [XLEN-1:0]    div_inst_done,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic [3:0]         dmem_wstrb,
  input  logic               dmem_ack,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               mem_stall,
  output logic               misaligned,
  output logic               w_reg_we,
  output logic [NREG_AW-1:0] w_rd_addr,
  output logic [XLEN-1:0]    w_data,
  output logic [XLEN-1:0]    w_pc,
  output logic [XLEN-1:0]    w_inst
);

  mem_state_t      state;
  logic            wait_we;
  logic [XLEN-1:0] wait_addr;
  logic [XLEN-1:0] wait_wdata;
  logic [3:0]      wait_wstrb;
  logic            hold_vld;
  logic [XLEN-1:0] hold_data;

  logic            bypass;
  logic [XLEN-1:0] store_src;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] m_result;
  logic [3:0]      lane_wstrb;
  logic            size_bad;
  logic            mem_op;
  logic            bad;
  logic            issue;
  logic            in_wait;
  logic            done;
  logic            m_ready;
  logic            div_vld;
  logic            collide;

  assign bypass    = w_reg_we && (w_rd_addr != '0) && (w_rd_addr == m_rs2_addr);
  assign store_src = bypass ? w_data : m_store_data;

  stage_mem_wb_load_store_align u_align (
    .funct3     (m_funct3),
    .addr_lo    (m_alu_result[1:0]),
    .store_data (store_src),
    .rdata      (dmem_rdata),
    .wstrb      (lane_wstrb),
    .wdata      (lane_wdata),
    .load_data  (load_data),
    .misaligned (size_bad)
  );

  // A held op has already finished its access; it only waits for the W port.
  assign mem_op  = (m_load | m_mem_we) & ~rst;
  assign bad     = mem_op & size_bad;
  assign issue   = mem_op & ~size_bad & ~hold_vld & (state == ST_IDLE);
  assign in_wait = (state == ST_WAIT) & ~rst;
  assign done    = (issue | in_wait) & dmem_ack;
  assign m_ready = ~mem_op | bad | hold_vld | done;
  assign div_vld = div_busy_7[6];
  assign collide = div_vld & m_ready & m_reg_we & ~bad & ~rst;
  assign m_result = m_load ? (hold_vld ? hold_data : load_data) : m_alu_result;

  assign dmem_req   = issue | in_wait;
  assign dmem_we    = in_wait ? wait_we : m_mem_we;
  assign dmem_addr  = in_wait ? wait_addr : {m_alu_result[XLEN-1:2], 2'b00};
  assign dmem_wdata = in_wait ? wait_wdata : lane_wdata;
  assign dmem_wstrb = in_wait ? wait_wstrb : lane_wstrb;
  assign mem_stall  = ((issue | in_wait) & ~dmem_ack) | collide;
  assign misaligned = bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_we    <= 1'b0;
      wait_addr  <= '0;
      wait_wdata <= '0;
      wait_wstrb <= '0;
      hold_vld   <= 1'b0;
      hold_data  <= '0;
      w_reg_we   <= 1'b0;
      w_rd_addr  <= '0;
      w_data     <= '0;
      w_pc       <= '0;
      w_inst     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (issue && !dmem_ack) begin
          state      <= ST_WAIT;
          wait_we    <= m_mem_we;
          wait_addr  <= {m_alu_result[XLEN-1:2], 2'b00};
          wait_wdata <= lane_wdata;
          wait_wstrb <= lane_wstrb;
        end
        ST_WAIT: if (dmem_ack) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      hold_vld <= collide;
      if (collide) hold_data <= m_result;

      if (div_vld) begin
        w_reg_we  <= 1'b1;
        w_rd_addr <= div_busy_7[4:0];
        w_data    <= div_busy_7[5] ? div_remainder : div_quotient;
        w_pc      <= div_pc_done;
        w_inst    <= div_inst_done;
      end else if (m_ready && m_reg_we && !bad) begin
        w_reg_we  <= 1'b1;
        w_rd_addr <= m_rd_addr;
        w_data    <= m_result;
        w_pc      <= m_pc;
        w_inst    <= m_inst;
      end else begin
        w_reg_we  <= 1'b0;
      end
    end
  end

endmodule
